// File: rtl/mac_4_2_pipelined.sv
// Pipelined multiply-accumulate: partial products reduced by a 4:2 compressor tree,
// a carry-propagate add into a product register, then a wrapping or saturating accumulator.
module mac_4_2_pipelined #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 20,
    parameter int unsigned SIGNED    = 0,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 In_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 Acc_clear,
    output logic                 Out_valid,
    output logic [ACC_WIDTH-1:0] Acc,
    output logic                 Overflow
);

    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned AW  = ACC_WIDTH;
    localparam int unsigned NR0 = WIDTH + 1;            // PP rows plus Baugh-Wooley constant row
    localparam int unsigned NRP = ((NR0 + 3) / 4) * 4;
    localparam int unsigned IW  = $clog2(NRP);

    typedef logic [PW-1:0]           row_t;
    typedef logic [NRP-1:0][PW-1:0]  rows_t;

    // Rows left after one compressor level; a trailing group of 3 is padded with a zero row.
    function automatic int unsigned next_rows(input int unsigned n);
        return 2 * (n / 4) + (((n % 4) == 3) ? 2 : (n % 4));
    endfunction

    localparam int unsigned NR1 = next_rows(NR0);

    // One row-wide 4:2 compressor: two chained full adders per column, Cout feeds the next column's Cin.
    function automatic void compress42(input row_t x0, input row_t x1, input row_t x2,
                                       input row_t x3, output row_t s, output row_t c);
        logic cin, co, s1;
        s   = '0;
        c   = '0;
        cin = 1'b0;
        for (int i = 0; i < int'(PW); i++) begin
            s1   = x0[i] ^ x1[i] ^ x2[i];
            co   = (x0[i] & x1[i]) | (x0[i] & x2[i]) | (x1[i] & x2[i]);
            s[i] = s1 ^ x3[i] ^ cin;
            if (i < int'(PW) - 1) begin
                c[i+1] = (s1 & x3[i]) | (s1 & cin) | (x3[i] & cin);
            end
            cin = co;
        end
    endfunction

    // One tree level over the first n rows; rows at or beyond n are zero on entry and exit.
    function automatic rows_t compress_level(input rows_t rin, input int unsigned n);
        rows_t       rout;
        row_t        s, c;
        int unsigned nout;
        rout = '0;
        nout = 0;
        for (int unsigned g = 0; g < NRP; g += 4) begin
            if (g < n) begin
                if ((n - g) >= 3) begin
                    compress42(rin[IW'(g)], rin[IW'(g + 1)], rin[IW'(g + 2)], rin[IW'(g + 3)], s, c);
                    rout[IW'(nout)]     = s;
                    rout[IW'(nout + 1)] = c;
                    nout                = nout + 2;
                end else begin
                    rout[IW'(nout)]     = rin[IW'(g)];
                    rout[IW'(nout + 1)] = rin[IW'(g + 1)];
                    nout                = nout + (n - g);
                end
            end
        end
        return rout;
    endfunction

    logic              in_valid_q, in_valid_d, clr_q, clr_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              s1_valid_q, s1_valid_d, s1_clr_q, s1_clr_d;
    rows_t             s1_rows_q, s1_rows_d;
    logic              s2_valid_q, s2_valid_d, s2_clr_q, s2_clr_d;
    row_t              prod_q, prod_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic              ovf_q, ovf_d, out_valid_q, out_valid_d;

    rows_t             pp_rows, tree_rows;
    int unsigned       tree_n;
    logic [AW:0]       prod_ext, acc_ext, sum;
    logic [AW-1:0]     sat_val;
    logic              out_of_range, pbit;

    // Input capture, S1 (PP generation + first level), S2 (remaining levels + CPA)
    always_comb begin
        in_valid_d = In_valid;
        clr_d      = Acc_clear;
        a_d        = A;
        b_d        = B;

        pp_rows = '0;
        for (int j = 0; j < int'(WIDTH); j++) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                pbit = a_q[i] & b_q[j];
                if ((SIGNED != 0) && ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1))) begin
                    pbit = ~pbit;
                end
                pp_rows[j][i+j] = pbit;
            end
        end
        if (SIGNED != 0) begin
            pp_rows[WIDTH][WIDTH]  = 1'b1;
            pp_rows[WIDTH][PW-1]   = 1'b1;
        end
        s1_rows_d  = compress_level(pp_rows, NR0);
        s1_valid_d = in_valid_q;
        s1_clr_d   = clr_q;

        tree_rows = s1_rows_q;
        tree_n    = NR1;
        for (int l = 0; l < int'(NRP); l++) begin
            if (tree_n > 2) begin
                tree_rows = compress_level(tree_rows, tree_n);
                tree_n    = next_rows(tree_n);
            end
        end
        prod_d     = tree_rows[0] + tree_rows[1];
        s2_valid_d = s1_valid_q;
        s2_clr_d   = s1_clr_q;
    end

    // S3: accumulate one bit wider than the accumulator, then wrap or clamp
    always_comb begin
        prod_ext = {{(AW + 1 - PW){(SIGNED != 0) & prod_q[PW-1]}}, prod_q};
        acc_ext  = {(SIGNED != 0) & acc_q[AW-1], acc_q};
        sum      = acc_ext + prod_ext;
        if (SIGNED != 0) begin
            out_of_range = sum[AW] ^ sum[AW-1];
            sat_val      = sum[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
        end else begin
            out_of_range = sum[AW];
            sat_val      = {AW{1'b1}};
        end

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = s2_valid_q;
        if (s2_valid_q) begin
            if (s2_clr_q) begin
                acc_d = prod_ext[AW-1:0];
                ovf_d = 1'b0;
            end else if (out_of_range) begin
                acc_d = (SATURATE != 0) ? sat_val : sum[AW-1:0];
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_q  <= 1'b0;
            clr_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s1_valid_q  <= 1'b0;
            s1_clr_q    <= 1'b0;
            s1_rows_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_clr_q    <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_valid_q  <= in_valid_d;
            clr_q       <= clr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s1_valid_q  <= s1_valid_d;
            s1_clr_q    <= s1_clr_d;
            s1_rows_q   <= s1_rows_d;
            s2_valid_q  <= s2_valid_d;
            s2_clr_q    <= s2_clr_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Acc       = acc_q;
    assign Overflow  = ovf_q;
    assign Out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_4_2_pipelined.sv
// Directed bench for mac_4_2_pipelined: unsigned wrap, unsigned saturate and signed saturate
// instances share one stimulus stream; each scenario checks the instance it targets.
module tb_mac_4_2_pipelined;

    logic        clk = 1'b0;
    logic        rst, in_valid, acc_clear;
    logic [7:0]  a, b;
    logic        ov0, ov1, ov2, of0, of1, of2;
    logic [19:0] acc0, acc1, acc2;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mac_4_2_pipelined #(.WIDTH(8), .ACC_WIDTH(20), .SIGNED(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .In_valid(in_valid), .A(a), .B(b), .Acc_clear(acc_clear),
        .Out_valid(ov0), .Acc(acc0), .Overflow(of0));
    mac_4_2_pipelined #(.WIDTH(8), .ACC_WIDTH(20), .SIGNED(0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .In_valid(in_valid), .A(a), .B(b), .Acc_clear(acc_clear),
        .Out_valid(ov1), .Acc(acc1), .Overflow(of1));
    mac_4_2_pipelined #(.WIDTH(8), .ACC_WIDTH(20), .SIGNED(1), .SATURATE(1)) u_sgn (
        .clk(clk), .rst(rst), .In_valid(in_valid), .A(a), .B(b), .Acc_clear(acc_clear),
        .Out_valid(ov2), .Acc(acc2), .Overflow(of2));

    // Present one input slot and advance past the edge that samples it.
    task automatic tick(input logic iv, input logic [7:0] ta, input logic [7:0] tb_v, input logic clr);
        in_valid  = iv;
        a         = ta;
        b         = tb_v;
        acc_clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(1'b1, 8'd12, 8'd34, 1'b0);
        tick(1'b1, 8'd56, 8'd78, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 8'd0, 8'd0, 1'b0);
            checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, ov0); end
            checks++; if (acc0 !== 20'd0) begin errors++; $display("FAIL reset_acc[%0d]: got %0d expected 0", k, acc0); end
            checks++; if (of0 !== 1'b0) begin errors++; $display("FAIL reset_overflow[%0d]: got %b expected 0", k, of0); end
            checks++; if ({ov2, of2, acc2} !== 22'd0) begin errors++; $display("FAIL reset_signed[%0d]: got %h expected 0", k, {ov2, of2, acc2}); end
        end
    endtask

    task automatic test_latency_accum;
        int          exp_acc;
        logic        exp_ov;
        for (int k = 0; k < 8; k++) begin
            tick(k < 4, 8'd255, 8'd255, k == 0);
            exp_ov  = (k >= 3) && (k <= 6);
            exp_acc = (k < 3) ? 0 : (k <= 6) ? 65025 * (k - 2) : 260100;
            checks++; if (ov0 !== exp_ov) begin errors++; $display("FAIL latency_out_valid[%0d]: got %b expected %b", k, ov0, exp_ov); end
            checks++; if (acc0 !== 20'(exp_acc)) begin errors++; $display("FAIL latency_acc[%0d]: got %0d expected %0d", k, acc0, exp_acc); end
            checks++; if (acc1 !== 20'(exp_acc)) begin errors++; $display("FAIL latency_acc_sat[%0d]: got %0d expected %0d", k, acc1, exp_acc); end
        end
    endtask

    task automatic test_overflow;
        for (int k = 0; k < 20; k++) begin
            tick(k < 17, 8'd255, 8'd255, k == 0);
            if (k == 18) begin
                checks++; if (acc0 !== 20'd1040400 || of0 !== 1'b0) begin errors++; $display("FAIL ovf_pre_wrap: got %0d/%b expected 1040400/0", acc0, of0); end
                checks++; if (acc1 !== 20'd1040400 || of1 !== 1'b0) begin errors++; $display("FAIL ovf_pre_sat: got %0d/%b expected 1040400/0", acc1, of1); end
            end
        end
        checks++; if (acc0 !== 20'd56849) begin errors++; $display("FAIL ovf_wrap_acc: got %0d expected 56849", acc0); end
        checks++; if (of0 !== 1'b1) begin errors++; $display("FAIL ovf_wrap_flag: got %b expected 1", of0); end
        checks++; if (acc1 !== 20'd1048575) begin errors++; $display("FAIL ovf_sat_acc: got %0d expected 1048575", acc1); end
        checks++; if (of1 !== 1'b1) begin errors++; $display("FAIL ovf_sat_flag: got %b expected 1", of1); end
        tick(1'b1, 8'd1, 8'd1, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0, 8'd0, 8'd0, 1'b0);
        checks++; if (acc0 !== 20'd1 || of0 !== 1'b0) begin errors++; $display("FAIL ovf_clear_wrap: got %0d/%b expected 1/0", acc0, of0); end
        checks++; if (acc1 !== 20'd1 || of1 !== 1'b0) begin errors++; $display("FAIL ovf_clear_sat: got %0d/%b expected 1/0", acc1, of1); end
    endtask

    task automatic test_signed;
        logic [7:0]  ta [3] = '{8'h80, 8'hFF, 8'h00};
        logic [7:0]  tbv[3] = '{8'h80, 8'h7F, 8'h05};
        logic [19:0] exp_acc[3] = '{20'd16384, 20'd16257, 20'd16257};
        for (int k = 0; k < 6; k++) begin
            if (k < 3) tick(1'b1, ta[k], tbv[k], k == 0);
            else       tick(1'b0, 8'd0, 8'd0, 1'b0);
            if (k >= 3) begin
                checks++; if (acc2 !== exp_acc[k-3]) begin errors++; $display("FAIL signed_acc[%0d]: got %0d expected %0d", k - 3, acc2, exp_acc[k-3]); end
                checks++; if (of2 !== 1'b0) begin errors++; $display("FAIL signed_overflow[%0d]: got %b expected 0", k - 3, of2); end
            end
        end
        for (int k = 0; k < 43; k++) tick(k < 40, 8'h80, 8'h7F, 1'b0);
        checks++; if (acc2 !== 20'h80000) begin errors++; $display("FAIL signed_sat_acc: got %h expected 80000", acc2); end
        checks++; if (of2 !== 1'b1) begin errors++; $display("FAIL signed_sat_flag: got %b expected 1", of2); end
    endtask

    task automatic test_bubbles;
        logic        iv [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0]  ta [5] = '{8'd3, 8'd0, 8'd0, 8'd5, 8'd7};
        logic [7:0]  tbv[5] = '{8'd4, 8'd0, 8'd0, 8'd6, 8'd8};
        logic        clr[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        exp_ov [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [19:0] exp_acc[5] = '{20'd12, 20'd12, 20'd12, 20'd42, 20'd56};
        for (int k = 0; k < 8; k++) begin
            if (k < 5) tick(iv[k], ta[k], tbv[k], clr[k]);
            else       tick(1'b0, 8'd0, 8'd0, 1'b0);
            if (k >= 3) begin
                checks++; if (ov0 !== exp_ov[k-3]) begin errors++; $display("FAIL bubble_out_valid[%0d]: got %b expected %b", k - 3, ov0, exp_ov[k-3]); end
                checks++; if (acc0 !== exp_acc[k-3]) begin errors++; $display("FAIL bubble_acc[%0d]: got %0d expected %0d", k - 3, acc0, exp_acc[k-3]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        tick(1'b1, 8'd5, 8'd5, 1'b1);
        tick(1'b1, 8'd5, 8'd5, 1'b0);
        tick(1'b1, 8'd5, 8'd5, 1'b0);
        rst = 1'b1;
        tick(1'b1, 8'd5, 8'd5, 1'b0);
        rst = 1'b0;
        checks++; if (acc0 !== 20'd0 || ov0 !== 1'b0 || of0 !== 1'b0) begin errors++; $display("FAIL midreset_state: got %0d/%b/%b expected 0/0/0", acc0, ov0, of0); end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 8'd0, 8'd0, 1'b0);
            checks++; if (ov0 !== 1'b0 || acc0 !== 20'd0) begin errors++; $display("FAIL midreset_flush[%0d]: got %b/%0d expected 0/0", k, ov0, acc0); end
        end
        tick(1'b1, 8'd2, 8'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 8'd0, 8'd0, 1'b0);
            if (k < 2) begin
                checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL midreset_early_valid[%0d]: got %b expected 0", k, ov0); end
            end
        end
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL midreset_next_valid: got %b expected 1", ov0); end
        checks++; if (acc0 !== 20'd4) begin errors++; $display("FAIL midreset_next_acc: got %0d expected 4", acc0); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        a         = 8'd0;
        b         = 8'd0;
        test_reset();
        test_latency_accum();
        test_overflow();
        test_signed();
        test_bubbles();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
